// File: rtl/ip_hdr_word_sequencer_pkg.sv
// Shared definitions for the IP header word sequencer: FSM state encodings,
// protocol constants and the per-packet descriptor layout.
package ip_hdr_word_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_HDR     = 3'd0;
    localparam state_t S_W1      = 3'd1;
    localparam state_t S_W2      = 3'd2;
    localparam state_t S_W3      = 3'd3;
    localparam state_t S_W4      = 3'd4;
    localparam state_t S_PAYLOAD = 3'd5;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef struct packed {
        logic is_ipv4;
        logic complete;
    } desc_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout shows the head entry whenever
// empty is low. Writes are dropped when full unless a read frees a slot.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 2,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign empty = (depth == '0);
    assign full  = depth[MAX_DEPTH_BITS];
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                depth <= depth + 1'b1;
            end else if (do_rd && !do_wr) begin
                depth <= depth - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_hdr_word_sequencer.sv
// Tracks packet word position, raises IP header word strobes, queues one
// descriptor per packet and merges it with the checksum unit's result.
module ip_hdr_word_sequencer
    import ip_hdr_word_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int INFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic                  word_ETH_IP_VER,
    output logic                  word_IP_LEN_ID,
    output logic                  word_IP_FRAG_TTL_PROTO,
    output logic                  word_IP_CHECKSUM_SRC_HI,
    output logic                  word_IP_SRC_DST,
    output logic                  word_IP_DST_LO,
    input  logic                  ip_checksum_vld,
    input  logic                  ip_checksum_is_good,
    input  logic                  ip_ttl_is_good,
    input  logic                  ip_hdr_has_options,
    output logic                  rd_checksum,
    output logic                  pkt_vld,
    output logic                  pkt_is_ipv4,
    output logic                  pkt_hdr_complete,
    output logic                  pkt_fwd_ok,
    input  logic                  pkt_ack
);

    // One slot of slack beyond the high-water mark covers the registered in_rdy.
    localparam logic [INFO_DEPTH_BITS:0] INFO_HI_WATER = {1'b0, {INFO_DEPTH_BITS{1'b1}}};

    state_t                   state;
    state_t                   state_next;
    logic                     is_ipv4_q;
    logic                     complete_q;
    logic                     data_word;
    logic                     eop;
    logic                     pop;
    desc_t                    desc_in;
    desc_t                    head;
    logic                     info_empty;
    logic [INFO_DEPTH_BITS:0] count;
    logic [INFO_DEPTH_BITS:0] count_next;
    logic                     data_unused;

    assign data_unused = ^{in_data[DATA_WIDTH-1:32], in_data[15:0]};

    assign data_word = in_wr & (in_ctrl == '0);
    assign eop       = in_wr & (in_ctrl != '0) & (state != S_HDR);

    always_comb begin
        state_next = state;
        if (data_word) begin
            case (state)
                S_HDR:   state_next = S_W1;
                S_W1:    state_next = S_W2;
                S_W2:    state_next = S_W3;
                S_W3:    state_next = S_W4;
                S_W4:    state_next = S_PAYLOAD;
                default: state_next = state;
            endcase
        end else if (eop) begin
            state_next = S_HDR;
        end
    end

    assign word_ETH_IP_VER         = data_word & (state == S_W1);
    assign word_IP_LEN_ID          = data_word & (state == S_W2);
    assign word_IP_FRAG_TTL_PROTO  = data_word & (state == S_W2);
    assign word_IP_CHECKSUM_SRC_HI = data_word & (state == S_W3);
    assign word_IP_SRC_DST         = data_word & (state == S_W3);
    assign word_IP_DST_LO          = data_word & (state == S_W4);

    assign desc_in = '{is_ipv4: is_ipv4_q, complete: complete_q};

    fallthrough_small_fifo #(
        .WIDTH          ($bits(desc_t)),
        .MAX_DEPTH_BITS (INFO_DEPTH_BITS)
    ) info_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (desc_in),
        .wr_en (eop),
        .rd_en (pop),
        .dout  (head),
        .empty (info_empty)
    );

    // Runt descriptors need no checksum result and never pop the result FIFO.
    assign pkt_vld          = ~info_empty & (~head.complete | ip_checksum_vld);
    assign pkt_is_ipv4      = ~info_empty & head.is_ipv4;
    assign pkt_hdr_complete = ~info_empty & head.complete;
    assign pkt_fwd_ok       = pkt_vld & head.is_ipv4 & head.complete &
                              ip_checksum_is_good & ip_ttl_is_good & ~ip_hdr_has_options;
    assign pop              = pkt_ack & pkt_vld;
    assign rd_checksum      = pop & head.complete;

    always_comb begin
        count_next = count;
        if (eop && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !eop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HDR;
            is_ipv4_q  <= 1'b0;
            complete_q <= 1'b0;
            count      <= '0;
            in_rdy     <= 1'b1;
        end else begin
            state  <= state_next;
            count  <= count_next;
            in_rdy <= (count_next < INFO_HI_WATER);
            if (data_word && state == S_HDR) begin
                is_ipv4_q  <= 1'b0;
                complete_q <= 1'b0;
            end
            if (word_ETH_IP_VER) begin
                is_ipv4_q <= (in_data[31:16] == ETHERTYPE_IPV4);
            end
            if (word_IP_DST_LO) begin
                complete_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ip_hdr_word_sequencer.sv
// Scoreboard bench: the driver queues expected strobes and verdicts, a
// monitor compares them, and a small model stands in for the checksum unit.
module tb_ip_hdr_word_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic        word_ETH_IP_VER, word_IP_LEN_ID, word_IP_FRAG_TTL_PROTO;
    logic        word_IP_CHECKSUM_SRC_HI, word_IP_SRC_DST, word_IP_DST_LO;
    logic        ip_checksum_vld = 1'b0;
    logic        ip_checksum_is_good = 1'b0;
    logic        ip_ttl_is_good = 1'b0;
    logic        ip_hdr_has_options = 1'b0;
    logic        rd_checksum;
    logic        pkt_vld, pkt_is_ipv4, pkt_hdr_complete, pkt_fwd_ok;
    logic        pkt_ack = 1'b0;

    always #5 clk = ~clk;

    ip_hdr_word_sequencer #(
        .DATA_WIDTH      (64),
        .CTRL_WIDTH      (8),
        .INFO_DEPTH_BITS (2)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_data                 (in_data),
        .in_ctrl                 (in_ctrl),
        .in_wr                   (in_wr),
        .in_rdy                  (in_rdy),
        .word_ETH_IP_VER         (word_ETH_IP_VER),
        .word_IP_LEN_ID          (word_IP_LEN_ID),
        .word_IP_FRAG_TTL_PROTO  (word_IP_FRAG_TTL_PROTO),
        .word_IP_CHECKSUM_SRC_HI (word_IP_CHECKSUM_SRC_HI),
        .word_IP_SRC_DST         (word_IP_SRC_DST),
        .word_IP_DST_LO          (word_IP_DST_LO),
        .ip_checksum_vld         (ip_checksum_vld),
        .ip_checksum_is_good     (ip_checksum_is_good),
        .ip_ttl_is_good          (ip_ttl_is_good),
        .ip_hdr_has_options      (ip_hdr_has_options),
        .rd_checksum             (rd_checksum),
        .pkt_vld                 (pkt_vld),
        .pkt_is_ipv4             (pkt_is_ipv4),
        .pkt_hdr_complete        (pkt_hdr_complete),
        .pkt_fwd_ok              (pkt_fwd_ok),
        .pkt_ack                 (pkt_ack)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int         ready;
        logic [2:0] res;
    } pend_t;

    logic [5:0] sq[$];     // strobes {ETH, LEN, FRAG, CSUM_HI, SRC_DST, DST_LO}
    logic [3:0] vq[$];     // verdict {is_ipv4, complete, fwd_ok, rd_checksum}
    pend_t      pend[$];
    logic [2:0] rq[$];     // visible results {csum_good, ttl_good, options}
    logic       rd_q = 1'b0;
    logic       flush_req = 1'b0;
    logic       three_sent = 1'b0;
    logic [5:0] st_now;
    pend_t      pe;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checksum-unit stand-in: result visible 3 cycles after the DST_LO word.
    always @(negedge clk) rd_q = rd_checksum;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (flush_req) begin
            rq.delete();
            pend.delete();
        end
        if (rd_q) begin
            n_vec++;
            if (rq.size() == 0) begin
                n_err++;
                $display("FAIL csum_pop: rd_checksum got 1 with no result queued, required 0");
            end else begin
                void'(rq.pop_front());
            end
        end
        while (pend.size() > 0 && pend[0].ready <= cyc) begin
            pe = pend.pop_front();
            rq.push_back(pe.res);
        end
        ip_checksum_vld     = (rq.size() > 0);
        ip_checksum_is_good = (rq.size() > 0) ? rq[0][2] : 1'b0;
        ip_ttl_is_good      = (rq.size() > 0) ? rq[0][1] : 1'b0;
        ip_hdr_has_options  = (rq.size() > 0) ? rq[0][0] : 1'b0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            st_now = {word_ETH_IP_VER, word_IP_LEN_ID, word_IP_FRAG_TTL_PROTO,
                      word_IP_CHECKSUM_SRC_HI, word_IP_SRC_DST, word_IP_DST_LO};
            if (in_wr) begin
                if (sq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL strobe_q: word seen with no expectation, got %b", st_now);
                end else begin
                    check("strobes", {2'b00, st_now}, {2'b00, sq.pop_front()});
                end
            end else begin
                check("strobes_idle", {2'b00, st_now}, 8'h00);
            end
            if (pkt_vld && pkt_ack) begin
                if (vq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL verdict_q: verdict popped with none expected");
                end else begin
                    check("verdict", {4'h0, pkt_is_ipv4, pkt_hdr_complete, pkt_fwd_ok, rd_checksum},
                          {4'h0, vq.pop_front()});
                end
            end
        end
    end

    task automatic wait_rdy();
        @(posedge clk);
        #1;
        in_wr = 1'b0;
        for (int t = 0; t < 300 && !in_rdy; t++) begin
            @(posedge clk);
            #1;
        end
        if (!in_rdy) begin
            $display("FAIL in_rdy_timeout: in_rdy got 0 required 1 within 300 cycles");
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
            $fatal(1, "in_rdy stuck low");
        end
    endtask

    // Header word, n_data data words, optional EOP; res/exp_v hand-computed by caller.
    task automatic send_pkt(input logic [15:0] etype, input int n_data, input bit with_eop,
                            input logic [2:0] res, input logic [3:0] exp_v);
        logic [15:0] other;
        pend_t p;
        other = (etype == 16'h0800) ? 16'h86DD : 16'h0800;
        for (int w = -1; w <= n_data; w++) begin
            if (w == n_data && !with_eop) break;
            wait_rdy();
            if (w < 0) begin
                in_ctrl = 8'hFF;
                in_data = 64'h0001_0002_0800_0004;
                sq.push_back(6'b000000);
            end else if (w == n_data) begin
                in_ctrl = 8'h01;
                in_data = 64'h0800_0800_0800_0800;
                sq.push_back(6'b000000);
                vq.push_back(exp_v);
            end else begin
                in_ctrl = 8'h00;
                in_data = {32'h4500_0054, (w == 1) ? etype : other, 16'h4500};
                case (w)
                    1:       sq.push_back(6'b100000);
                    2:       sq.push_back(6'b011000);
                    3:       sq.push_back(6'b000110);
                    4:       sq.push_back(6'b000001);
                    default: sq.push_back(6'b000000);
                endcase
                if (w == 4) begin
                    p.ready = cyc + 4;
                    p.res   = res;
                    pend.push_back(p);
                end
            end
            in_wr = 1'b1;
        end
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic ack_one();
        for (int t = 0; t < 100 && !pkt_vld; t++) begin
            @(negedge clk);
        end
        if (!pkt_vld) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_wait: pkt_vld got 0 required 1 within 100 cycles");
        end else begin
            @(posedge clk);
            #1;
            pkt_ack = 1'b1;
            @(posedge clk);
            #1;
            pkt_ack = 1'b0;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_rdy", {7'h0, in_rdy}, 8'h01);
        check("rst_pkt_vld", {7'h0, pkt_vld}, 8'h00);
        check("rst_rd_checksum", {7'h0, rd_checksum}, 8'h00);
        check("rst_fwd_ok", {7'h0, pkt_fwd_ok}, 8'h00);

        // 1: good IPv4 packet
        send_pkt(16'h0800, 7, 1'b1, 3'b110, 4'b1111);
        ack_one();

        // 2: runt ending after data word 2
        send_pkt(16'h0800, 3, 1'b1, 3'b110, 4'b1000);
        @(negedge clk);
        check("runt_vld_now", {7'h0, pkt_vld}, 8'h01);
        ack_one();

        // 3: ARP, EOP right after word 4: verdict waits for the checksum result
        send_pkt(16'h0806, 5, 1'b1, 3'b110, 4'b0101);
        @(negedge clk);
        check("vld_before_csum", {7'h0, pkt_vld}, 8'h00);
        @(negedge clk);
        check("vld_with_csum", {7'h0, pkt_vld}, 8'h01);
        ack_one();

        // 4: four back-to-back packets against the high-water mark
        fork
            begin
                send_pkt(16'h0800, 6, 1'b1, 3'b110, 4'b1111);
                send_pkt(16'h0806, 6, 1'b1, 3'b110, 4'b0101);
                send_pkt(16'h0800, 2, 1'b1, 3'b110, 4'b1000);
                check("rdy_low_at_3", {7'h0, in_rdy}, 8'h00);
                three_sent = 1'b1;
                send_pkt(16'h0800, 6, 1'b1, 3'b010, 4'b1101);
            end
            begin
                for (int t = 0; t < 500 && !three_sent; t++) @(negedge clk);
                repeat (3) @(negedge clk);
                check("rdy_held_low", {7'h0, in_rdy}, 8'h00);
                ack_one();
                check("rdy_restored", {7'h0, in_rdy}, 8'h01);
            end
        join
        repeat (3) ack_one();

        // 5: TTL expired, runt, good, options -- runt must not shift results
        send_pkt(16'h0800, 6, 1'b1, 3'b100, 4'b1101);
        send_pkt(16'h0800, 2, 1'b1, 3'b110, 4'b1000);
        send_pkt(16'h0800, 6, 1'b1, 3'b110, 4'b1111);
        repeat (3) ack_one();
        send_pkt(16'h0800, 5, 1'b1, 3'b111, 4'b1101);
        ack_one();

        // 6: reset while in S_W3 with two descriptors queued
        send_pkt(16'h0800, 5, 1'b1, 3'b110, 4'b1111);
        send_pkt(16'h0800, 5, 1'b1, 3'b110, 4'b1111);
        send_pkt(16'h0800, 3, 1'b0, 3'b110, 4'b0000);
        repeat (5) @(negedge clk);
        check("pre_reset_vld", {7'h0, pkt_vld}, 8'h01);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vq.delete();
        @(negedge clk);
        check("post_reset_vld", {7'h0, pkt_vld}, 8'h00);
        check("post_reset_rdy", {7'h0, in_rdy}, 8'h01);
        flush_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        flush_req = 1'b0;
        send_pkt(16'h0800, 7, 1'b1, 3'b110, 4'b1111);
        ack_one();

        repeat (6) @(negedge clk);
        check("verdicts_drained", vq.size()[7:0], 8'h00);
        check("results_drained", rq.size()[7:0], 8'h00);
        check("final_vld", {7'h0, pkt_vld}, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
